// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite responder exposing RW registers plus one read-only status word
module axil_reg_slave #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [DATA_WIDTH-1:0]          status_i
);
  localparam logic [9:0] STATUS_IDX = 10'(NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  logic                  aw_held;
  logic                  w_held;
  logic [9:0]            aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [9:0]            wr_idx;
  logic [9:0]            rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr;
  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;
  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = aw_hs ? s_axi_awaddr[11:2] : aw_idx_q;
  assign wr_data = w_hs ? s_axi_wdata : wdata_q;
  assign rd_idx  = s_axi_araddr[11:2];
  assign unused_addr = ^{s_axi_awaddr[ADDR_WIDTH-1:12], s_axi_awaddr[1:0],
                         s_axi_araddr[ADDR_WIDTH-1:12], s_axi_araddr[1:0]};
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
  // read mux: RW register, status word, or zero for unmapped indices
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) rd_val = (rd_idx == 10'(i)) ? regs[i] : rd_val;
    rd_val = (rd_idx == STATUS_IDX) ? status_i : rd_val;
  end
  // AW and W holding registers; both clear on the commit edge
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
    end else begin
      aw_held <= !commit && (aw_held || aw_hs);
      w_held  <= !commit && (w_held || w_hs);
      if (aw_hs) aw_idx_q <= s_axi_awaddr[11:2];
      if (w_hs) wdata_q <= s_axi_wdata;
    end
  end
  // write response: raised on commit, held until the master accepts it
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
    end else if (commit) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= (wr_idx < STATUS_IDX) ? OKAY : SLVERR;
    end else if (s_axi_bvalid && s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end
  // register bank update and one-cycle write pulses
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= commit && (wr_idx == 10'(i));
        if (commit && (wr_idx == 10'(i))) regs[i] <= wr_data;
      end
    end
  end
  // read response: data captured at the AR handshake, held until accepted
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_val;
      s_axi_rresp  <= (rd_idx <= STATUS_IDX) ? OKAY : SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed AXI4-Lite stimulus with queue-based response scoreboard
module tb_axil_reg_slave;
  logic         aclk = 1'b0;
  logic         areset = 1'b0;
  logic [31:0]  s_axi_awaddr = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata = '0;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b1;
  logic [31:0]  s_axi_araddr = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b1;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr_pulse;
  logic [31:0]  status_i = '0;
  int n_checks = 0;
  int n_fail = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] model [8] = '{default: '0};

  axil_reg_slave dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .status_i(status_i)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] packed_model();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = model[i];
    return r;
  endfunction

  always @(negedge aclk) begin
    if (!areset && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected: got bresp %0h with no write outstanding", s_axi_bresp);
      end else chk("bresp", s_axi_bresp, bq.pop_front());
    end
    if (!areset && s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL r_unexpected: got rdata %0h with no read outstanding", s_axi_rdata);
      end else chk("rdata_rresp", {s_axi_rdata, s_axi_rresp}, rq.pop_front());
    end
  end

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one within 50 cycles", name);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge aclk);
    while ((s_axi_bvalid || s_axi_rvalid) && n < 50) begin n++; @(negedge aclk); end
    if (n >= 50) timeout("idle_timeout");
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [1:0] resp, input logic [7:0] pulse);
    int n = 0;
    bq.push_back(resp);
    @(posedge aclk); #1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin n++; @(negedge aclk); end
    if (n >= 50) timeout("wr_timeout");
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    for (int i = 0; i < 8; i++) if (pulse[i]) model[i] = data;
    chk("wr_bvalid", s_axi_bvalid, 1'b1);
    chk("wr_pulse", reg_wr_pulse, pulse);
    chk("wr_reg_q", reg_q, packed_model());
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    rq.push_back({data, resp});
    @(posedge aclk); #1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    @(negedge aclk);
    while (!s_axi_arready && n < 50) begin n++; @(negedge aclk); end
    if (n >= 50) timeout("rd_timeout");
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    chk("rd_rvalid", s_axi_rvalid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 areset = 1'b1;
    #1;
    chk("rst_outputs", {s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata}, '0);
    chk("rst_reg_q", reg_q, '0);
    chk("rst_pulse", reg_wr_pulse, '0);
    repeat (2) @(posedge aclk);
    @(negedge aclk) areset = 1'b0;
    @(negedge aclk);
    chk("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    wr(32'h004, 32'hDEADBEEF, 2'b00, 8'b0000_0010);
    @(posedge aclk); #1;
    chk("pulse_one_cycle", reg_wr_pulse, 8'h00);
    chk("b_done", s_axi_bvalid, 1'b0);
    rd(32'h004, 32'hDEADBEEF, 2'b00);

    wait_idle();
    s_axi_bready = 1'b0;
    @(posedge aclk); #1;
    s_axi_wdata = 32'h0BADF00D; s_axi_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0;
    chk("w_only_readies", {s_axi_wready, s_axi_awready, s_axi_bvalid}, 3'b010);
    @(posedge aclk); #1;
    chk("w_only_no_commit", reg_q[255:224], 32'h0);
    @(posedge aclk); #1;
    s_axi_awaddr = 32'h01C; s_axi_awvalid = 1'b1;
    bq.push_back(2'b00);
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    model[7] = 32'h0BADF00D;
    chk("late_aw_bvalid", s_axi_bvalid, 1'b1);
    chk("late_aw_pulse", reg_wr_pulse, 8'h80);
    chk("late_aw_reg_q", reg_q, packed_model());
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      chk("b_stall", {s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_bresp}, 5'b10000);
    end
    s_axi_bready = 1'b1;

    status_i = 32'h12345678;
    wait_idle();
    s_axi_rready = 1'b0;
    rd(32'h020, 32'h12345678, 2'b00);
    status_i = 32'hFFFFFFFF;
    repeat (2) begin
      @(posedge aclk); #1;
      chk("status_held", s_axi_rdata, 32'h12345678);
    end
    s_axi_rready = 1'b1;
    wr(32'h020, 32'hCAFEF00D, 2'b10, 8'h00);

    wait_idle();
    s_axi_rready = 1'b0;
    rd(32'h040, 32'h0, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      chk("r_stall", {s_axi_rvalid, s_axi_arready, s_axi_rdata, s_axi_rresp}, {2'b10, 32'h0, 2'b10});
    end
    s_axi_rready = 1'b1;
    wr(32'h040, 32'h11111111, 2'b10, 8'h00);
    wr(32'hABCD1008, 32'h55AA55AA, 2'b00, 8'h04);
    rd(32'h008, 32'h55AA55AA, 2'b00);

    wait_idle();
    @(posedge aclk); #1;
    s_axi_araddr = 32'h000; s_axi_arvalid = 1'b1;
    s_axi_awaddr = 32'h000; s_axi_wdata = 32'hA5A5A5A5; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    rq.push_back({32'h0, 2'b00});
    bq.push_back(2'b00);
    @(negedge aclk);
    chk("same_edge_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    model[0] = 32'hA5A5A5A5;
    chk("same_edge_both_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
    chk("same_edge_reg_q", reg_q, packed_model());
    rd(32'h000, 32'hA5A5A5A5, 2'b00);

    wait_idle();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    @(posedge aclk); #1;
    s_axi_awaddr = 32'h00C; s_axi_wdata = 32'h33333333; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h00C; s_axi_arvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    #3 areset = 1'b1;
    #1;
    model = '{default: '0};
    chk("midrst_valids", {s_axi_bvalid, s_axi_rvalid, s_axi_rdata}, '0);
    chk("midrst_reg_q", reg_q, '0);
    @(negedge aclk) areset = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("midrst_no_resp", {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready}, 5'b00111);
    end
    @(posedge aclk); #1;
    s_axi_wdata = 32'h77777777; s_axi_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0;
    chk("w_held_before_rst", s_axi_wready, 1'b0);
    #3 areset = 1'b1;
    #1 chk("w_hold_dropped", s_axi_wready, 1'b1);
    @(negedge aclk) areset = 1'b0;
    @(posedge aclk); #1;
    s_axi_awaddr = 32'h000; s_axi_awvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    repeat (2) begin
      @(posedge aclk); #1;
      chk("aw_alone_waits", {s_axi_bvalid, s_axi_awready, reg_q[31:0]}, {2'b00, 32'h0});
    end
    bq.push_back(2'b00);
    s_axi_wdata = 32'h99999999; s_axi_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_wvalid = 1'b0;
    model[0] = 32'h99999999;
    chk("aw_then_w_commit", {s_axi_bvalid, reg_wr_pulse}, {1'b1, 8'h01});
    chk("aw_then_w_reg_q", reg_q, packed_model());

    wait_idle();
    repeat (2) @(negedge aclk);
    chk("scoreboard_drained", {bq.size(), rq.size()}, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite responder that terminates one slave port of the system AXI interconnect and exposes a bank of software-visible 32-bit registers to user logic. It accepts write address and write data independently, commits writes, and returns B and R responses with full valid/ready backpressure. It is the register front-end for the custom slave IPs hanging off the interconnect's slave ports.

## Interface
- NUM_REGS, 8, number of read/write registers (1..255); index NUM_REGS is the read-only status register
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data and register width (fixed 32)
- aclk  in  1  single clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  DATA_WIDTH  write data (no strobes; full-word writes only)
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bresp  out  2  write response, 2'b00 OKAY, 2'b10 SLVERR
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response, encoding as bresp
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- reg_q  out  NUM_REGS*DATA_WIDTH  current register contents, register i at bits [i*32 +: 32]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse per register on write commit
- status_i  in  DATA_WIDTH  value returned for reads of index NUM_REGS

## Operation
- Decode: word index = addr[11:2]; addr[1:0] and addr[ADDR_WIDTH-1:12] ignored (4 KB window). Index < NUM_REGS: RW register. Index == NUM_REGS: status (RO). Index > NUM_REGS: unmapped.
- Write channel: AW and W captured independently into holding registers (aw_held, w_held). awready = !aw_held && !bvalid; wready = !w_held && !bvalid. AW and W may arrive in either order or same cycle.
- Commit: first edge at which both are held (or handshake together with the other held) commits the write: RW index updates register and pulses reg_wr_pulse[i]; status or unmapped index discards data. Holds cleared; bvalid set.
- bresp: OKAY for RW index; SLVERR for status index and unmapped.
- One outstanding write; B held stable until bvalid && bready.
- Read channel: arready = !rvalid. AR handshake captures data: RW register, status_i, or 0 for unmapped. rresp OKAY for index <= NUM_REGS, SLVERR otherwise. One outstanding read; R held stable until rvalid && rready.
- Read and write channels independent; both may complete in the same cycle.

## Timing
- Reset (async assert, sync release): reg_q = 0, reg_wr_pulse = 0, bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0, holds cleared; hence awready = wready = arready = 1.
- Write latency: AW and W handshake at edge T -> register, reg_q and reg_wr_pulse updated after T, bvalid = 1 in cycle T+1. Staggered arrival: latency counts from later handshake.
- Read latency: AR handshake at edge T -> rvalid/rdata valid in cycle T+1.
- Back-to-back: with bready held high, next AW/W accepted in cycle after B handshake (awready low while bvalid); sustained throughput 1 write per 2 cycles, same for reads.
- Read and write commit on same register at same edge: read returns pre-write value.
- status_i sampled at AR handshake edge only; later changes do not alter pending rdata.
- Reset mid-transaction: pending B/R dropped, held AW/W discarded, no further response for those transactions.

## Test plan
- Reset: assert areset mid-cycle -> all outputs at reset values immediately; after release awready = wready = arready = 1.
- Write 0xDEADBEEF to 0x004 with AW/W same cycle, bready=1 -> reg_q[63:32] = 0xDEADBEEF, reg_wr_pulse = 8'b0000_0010 for one cycle, bvalid one cycle after handshake, bresp 00; read 0x004 -> rdata 0xDEADBEEF, rresp 00.
- W 3 cycles before AW (address 0x01C), then bready low 4 cycles -> commit on AW edge, bvalid held 4+ cycles with awready/wready low, reg_q[255:224] updated.
- status_i = 0x1234_5678, read 0x020 -> rdata 0x12345678 OKAY; write 0x020 -> SLVERR, no reg_q change, no pulse.
- Read 0x040 (unmapped) -> rdata 0, rresp 10; write 0x040 -> bresp 10; rready held low 3 cycles -> rvalid/rdata stable, arready low.
- Same-edge read and write of 0x000 (old 0x0, new 0xA5A5A5A5) -> rdata 0x0, subsequent read 0xA5A5A5A5.
